adam_periph_uart_rx_ctrl: RTL
=============================

ADAM_PERIPH_UART_RX_CTRL -- requirements
Module: adam_periph_uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of DATA_T (bus word, timeout and threshold width).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pause_req  in  1  pause request, 4-phase handshake.
REQ-006 SHALL have port pause_ack  out  1  pause acknowledge.
REQ-007 SHALL have port enable  in  1  receive enable; 0 drops incoming bytes.
REQ-008 SHALL have port threshold  in  DATA_WIDTH  FIFO level that raises irq.
REQ-009 SHALL have port timeout  in  DATA_WIDTH  idle-cycle limit; 0 disables timeout.
REQ-010 SHALL have port in_data, in_valid, in_ready  in/in/out  8/1/1  byte stream from adam_periph_uart_rx.
REQ-011 SHALL have port out_data, out_valid, out_ready  out/out/in  DATA_WIDTH/1/1  byte stream to bus side, zero-extended.
REQ-012 SHALL have port level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port overrun_clr  in  1  one-cycle pulse clearing overrun.
REQ-014 SHALL have ports overrun, timed_out, irq  out  1 each  sticky overrun, idle timeout flag, interrupt.

Function
REQ-015 SHALL implement FSM RUN, PAUSING, PAUSED, RESUMING; reset state RUN.
REQ-016 In RUN, in_ready SHALL be 1; a byte (in_valid=1) is pushed if enable=1 and FIFO not full, otherwise discarded.
REQ-017 A byte discarded for full FIFO while enable=1 SHALL set overrun the next cycle; overrun stays 1 until overrun_clr.
REQ-018 Push while full with pop in same cycle SHALL be accepted, no overrun, level unchanged.
REQ-019 out_valid SHALL equal (FIFO not empty) in RUN; out_data = head entry (first-word fall-through, 0-cycle read latency).
REQ-020 Pop SHALL occur when out_valid and out_ready; push-to-out_valid latency 1 cycle.
REQ-021 Pointers SHALL wrap modulo DEPTH; level = push count minus pop count, range 0..DEPTH.
REQ-022 Idle counter SHALL clear on any push or pop, increment each RUN cycle while level>0, saturate at timeout.
REQ-023 timed_out SHALL be set when timeout!=0 and idle counter reaches timeout; cleared on next pop or push.
REQ-024 irq SHALL equal (level>=threshold and threshold!=0) OR timed_out OR overrun, registered.
REQ-025 RUN -> PAUSING on pause_req=1; in PAUSING in_ready=1 and bytes still accepted, out_valid=0.
REQ-026 PAUSING -> PAUSED when in_valid=0 for that cycle; PAUSED asserts pause_ack=1, in_ready=0, out_valid=0, idle counter frozen, FIFO contents kept.
REQ-027 PAUSED -> RESUMING on pause_req=0; RESUMING drives pause_ack=0 for one cycle, then RUN.
REQ-028 overrun_clr coincident with a new overrun event SHALL leave overrun set.

Reset
REQ-029 On rst=0 (asynchronous) SHALL clear pointers, level=0, overrun=0, timed_out=0, irq=0, idle counter=0, pause_ack=0, out_valid=0, in_ready=0, state RUN.
REQ-030 Reset mid-frame or mid-pause SHALL discard FIFO contents; first cycle after release in_ready=1.

Structure
REQ-031 State enum and DEPTH default SHALL reside in shared package adam_periph_uart_pkg.
REQ-032 FIFO storage/pointers SHALL be sub-module adam_periph_uart_rx_fifo; FSM, timeout and irq logic in top.

Verification
REQ-033 Push bytes 0x00..0x07 (DEPTH=8), out_ready=0 -> level=8, no overrun; then drain -> out_data 0..7 in order, level=0.
REQ-034 Fill to 8, push 0x55 with out_ready=0 -> 0x55 dropped, overrun=1, irq=1; overrun_clr -> overrun=0.
REQ-035 Full FIFO, push and pop same cycle -> overrun=0, level stays 8, new byte at tail.
REQ-036 threshold=0, timeout=100, push 1 byte, idle -> timed_out=1 at 100 idle cycles, irq=1; pop clears.
REQ-037 pause_req=1 with byte arriving -> byte stored, pause_ack=1 after in_valid low, out_valid=0; release -> ack=0, RUN, data intact.
REQ-038 Assert rst mid-stream with level=5 -> level=0, all flags 0 immediately, asynchronous to clk.

Source files
------------

// File: rtl/adam_periph_uart_pkg.sv
// Shared definitions for the UART peripheral blocks.
//   UART_RX_FIFO_DEPTH : default receive FIFO depth
//   rx_state_e         : receive controller sequencing states
package adam_periph_uart_pkg;

  localparam int unsigned UART_RX_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    RX_RUN      = 2'd0,
    RX_PAUSING  = 2'd1,
    RX_PAUSED   = 2'd2,
    RX_RESUMING = 2'd3
  } rx_state_e;

endpackage

// File: rtl/adam_periph_uart_rx_fifo.sv
// Receive byte FIFO with first-word fall-through read.
//   clk, rst       : clock, async active-low reset (clears pointers/level)
//   push, wr_data  : write strobe and byte (caller guarantees not full unless popping)
//   pop            : read strobe (caller guarantees not empty)
//   rd_data        : head entry, valid whenever empty=0
//   full, empty    : occupancy flags
//   level          : current occupancy, 0..DEPTH
//   level_nxt      : occupancy after this cycle's push/pop
module adam_periph_uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_nxt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/adam_periph_uart_rx_ctrl.sv
// UART receive controller: buffers bytes from the rx shifter, presents them
// to the bus side, tracks overrun/idle timeout/threshold interrupts and
// supports a 4-phase pause handshake.
//   clk, rst                       : clock, async active-low reset
//   pause_req / pause_ack          : pause handshake
//   enable                         : 0 drops incoming bytes
//   threshold, timeout             : irq level (0 = off), idle limit (0 = off)
//   in_data/in_valid/in_ready      : byte stream in
//   out_data/out_valid/out_ready   : zero-extended byte stream out
//   level                          : FIFO occupancy
//   overrun_clr                    : clears sticky overrun
//   overrun, timed_out, irq        : status flags
//
// state       | meaning
// RX_RUN      | normal receive and drain
// RX_PAUSING  | still accepting bytes, draining stopped, waiting for idle input
// RX_PAUSED   | acknowledged; input and output halted, FIFO held
// RX_RESUMING | ack dropped for one cycle before returning to run
module adam_periph_uart_rx_ctrl
  import adam_periph_uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   threshold,
  input  logic [DATA_WIDTH-1:0]   timeout,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  input  logic                    overrun_clr,
  output logic                    overrun,
  output logic                    timed_out,
  output logic                    irq
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  rx_state_e             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pause_ack_q, pause_ack_d;
  logic                  overrun_q, overrun_d;
  logic                  timed_out_q, timed_out_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] idle_q, idle_d;

  logic                  push, pop, full, empty, overrun_evt;
  logic [7:0]            rd_data;
  logic [LVL_W-1:0]      fifo_level, fifo_level_nxt;

  adam_periph_uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (in_data),
    .pop       (pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level),
    .level_nxt (fifo_level_nxt)
  );

  assign out_valid = (state_q == RX_RUN) && !empty;
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is legal then.
  assign push        = in_valid && in_ready_q && enable && (!full || pop);
  assign overrun_evt = in_valid && in_ready_q && enable && full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_RUN:      if (pause_req) state_d = RX_PAUSING;
      RX_PAUSING:  if (!in_valid) state_d = RX_PAUSED;
      RX_PAUSED:   if (!pause_req) state_d = RX_RESUMING;
      RX_RESUMING: state_d = RX_RUN;
      default:     state_d = RX_RUN;
    endcase

    // Handshake outputs follow the next state so they align with it.
    in_ready_d  = (state_d == RX_RUN) || (state_d == RX_PAUSING);
    pause_ack_d = (state_d == RX_PAUSED);

    // New overrun wins over a coincident clear.
    overrun_d = overrun_evt || (overrun_q && !overrun_clr);

    if (push || pop) begin
      idle_d = '0;
    end else if (state_q == RX_RUN && !empty && idle_q < timeout) begin
      idle_d = idle_q + DATA_WIDTH'(1);
    end else begin
      idle_d = idle_q;
    end

    timed_out_d = !(push || pop) &&
                  (timed_out_q || (timeout != '0 && idle_d >= timeout));

    // Computed from next-cycle values so irq lines up with the flags it reflects.
    irq_d = ((threshold != '0) && (DATA_WIDTH'(fifo_level_nxt) >= threshold)) ||
            timed_out_d || overrun_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RX_RUN;
      in_ready_q  <= 1'b0;
      pause_ack_q <= 1'b0;
      overrun_q   <= 1'b0;
      timed_out_q <= 1'b0;
      irq_q       <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      pause_ack_q <= pause_ack_d;
      overrun_q   <= overrun_d;
      timed_out_q <= timed_out_d;
      irq_q       <= irq_d;
      idle_q      <= idle_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign pause_ack = pause_ack_q;
  assign overrun   = overrun_q;
  assign timed_out = timed_out_q;
  assign irq       = irq_q;
  assign level     = fifo_level;
  assign out_data  = DATA_WIDTH'(rd_data);

endmodule
